// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one synchronous memory port.
// One transaction in flight; read data returned after RD_LAT cycles.
module mem_rr_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] req_rdata,
    output logic              write,
    output logic              read,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               win_q;
    logic               last_gnt_q;
    logic               gnt0_q, gnt1_q;
    logic               write_q, read_q;
    logic               rvalid0_q, rvalid1_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  req_rdata_q;

    // Requester 1 wins when alone, or on a tie when 0 was granted last.
    logic               pick1_c;
    logic               sel_we_c;
    logic [ADDR_W-1:0]  sel_addr_c;
    logic [DATA_W-1:0]  sel_wdata_c;

    assign pick1_c     = req1 & (~req0 | ~last_gnt_q);
    assign sel_we_c    = pick1_c ? we1    : we0;
    assign sel_addr_c  = pick1_c ? addr1  : addr0;
    assign sel_wdata_c = pick1_c ? wdata1 : wdata0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            win_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_rdata_q <= '0;
        end else begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        win_q      <= pick1_c;
                        last_gnt_q <= pick1_c;
                        gnt0_q     <= ~pick1_c;
                        gnt1_q     <= pick1_c;
                        write_q    <= sel_we_c;
                        read_q     <= ~sel_we_c;
                        addr_q     <= sel_addr_c;
                        wdata_q    <= sel_we_c ? sel_wdata_c : '0;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (write_q) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= CNT_W'(RD_LAT - 1);
                        state_q <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    // Counter reaches 0 in the cycle memory rdata is valid.
                    if (cnt_q == '0) begin
                        req_rdata_q <= rdata;
                        rvalid0_q   <= ~win_q;
                        rvalid1_q   <= win_q;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign write     = write_q;
    assign read      = read_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign req_rdata = req_rdata_q;

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Two-requester round-robin arbiter that shares a single synchronous memory port between requesters 0 and 1. It serialises their read and write transactions onto the memory's write/read/addr/wdata strobes, and returns read data to the winning requester after the memory's fixed read latency. It sits between the requester agents and the memory model checked by the data-integrity assertions.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, memory read latency in cycles (legal 1..4): mem rdata valid RD_LAT cycles after the read strobe cycle
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0, req1  in  1  transaction request; held with we/addr/wdata stable until the matching gnt
- we0, we1  in  1  1 = write, 0 = read
- addr0, addr1  in  ADDR_W  request address
- wdata0, wdata1  in  DATA_W  write data
- gnt0, gnt1  out  1  one-cycle grant pulse, coincident with the memory strobe
- rvalid0, rvalid1  out  1  one-cycle read-data-valid pulse
- req_rdata  out  DATA_W  read data, valid only while an rvalid is high
- write  out  1  memory write strobe
- read  out  1  memory read strobe
- addr  out  ADDR_W  memory address
- wdata  out  DATA_W  memory write data
- rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, ISSUE, WAIT_RD, RESP.
- **IDLE**
  - At each edge, sample req0/req1.
  - None: stay in IDLE.
  - One: that requester wins.
  - Both: the requester not granted last wins.
  - Latch the winner's we/addr/wdata, set last_gnt = winner, go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - Drive gnt of the winner, plus write=we or read=!we, addr, and wdata (write only).
  - Write: go to IDLE.
  - Read: go to WAIT_RD with counter = RD_LAT-1.
  - req is not sampled in ISSUE.
- **WAIT_RD**
  - Count down. When the counter is 0, capture rdata at the edge and go to RESP.
  - For RD_LAT=1, WAIT_RD lasts 1 cycle, which is the cycle rdata is valid.
- **RESP** (1 cycle)
  - rvalid of the winner = 1; req_rdata = captured data.
  - Go to IDLE.
- Only one transaction is in flight at a time. No new grant is issued during WAIT_RD/RESP; pending requests wait.
- Requester protocol:
  - Deassert req at the edge ending the gnt cycle, or present the next request.
  - Because IDLE always follows, a held req re-arbitrates normally.
- Outside ISSUE: addr=0, wdata=0, write=0, read=0.
- Outside RESP: req_rdata=0.
- Outputs are all registered. No combinational path from req to any output.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE, last_gnt=1 (so requester 0 wins the first tie).
  - All outputs 0.
  - An in-flight read is abandoned and no rvalid is produced.
  - The first grant after reset_n rises needs a req sampled at a rising edge in IDLE.
- Grant latency: req sampled high at edge E (in IDLE) -> gnt and strobe in the cycle after E.
- Write throughput: one write per 2 cycles.
- Read:
  - strobe in cycle T, rdata valid in cycle T+RD_LAT, rvalid in cycle T+RD_LAT+1.
  - Next grant is no earlier than cycle T+RD_LAT+3.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1.
- A lone requester is granted back-to-back regardless of last_gnt.
- write and read are never high together. gnt0 and gnt1 are never high together.

## Test plan
- Reset then single write: req0=1, we0=1, addr0=0x10, wdata0=0xA5A5 -> next cycle gnt0=1, write=1, addr=0x10, wdata=0xA5A5. Following cycle all strobes are 0.
- Read, RD_LAT=1: req1=1, we1=0, addr1=0x10, memory returns 0xA5A5 the cycle after the read strobe -> rvalid1=1 with req_rdata=0xA5A5 exactly 2 cycles after gnt1. rvalid0 stays 0.
- Tie after reset: req0=req1=1 held with writes -> gnt sequence 0,1,0,1 on alternate cycle pairs; never both high.
- Lone requester: req1 held with 3 writes -> gnt1 in cycles 1, 3, 5. gnt0 never asserted.
- Read blocking, RD_LAT=3: read from 0, write request from 1 arriving during WAIT_RD -> gnt1 appears no earlier than the cycle after rvalid0 plus one IDLE cycle.
- Reset mid-read: assert reset_n=0 during WAIT_RD -> all outputs 0 immediately, no rvalid after release. First tie after release goes to requester 0.
